// File: rtl/clk_rate_ctrl.sv
// Rate controller for the clock divider: debounced button / direct-load mode select
// and the programmable period counter, with mode changes taken only at period boundaries.
module clk_rate_ctrl #(
    parameter int N          = 26,
    parameter int DIV0       = 50000000,
    parameter int DIV1       = 25000000,
    parameter int DIV2       = 5000000,
    parameter int DIV3       = 1000000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       mode_load,
    input  logic [1:0] mode_in,
    input  logic       run,
    output logic [1:0] mode,
    output logic       q,
    output logic       tick,
    output logic       pending
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    localparam logic [N-1:0] DIV0_C = N'(DIV0);
    localparam logic [N-1:0] DIV1_C = N'(DIV1);
    localparam logic [N-1:0] DIV2_C = N'(DIV2);
    localparam logic [N-1:0] DIV3_C = N'(DIV3);

    typedef enum logic [1:0] {
        DEB_IDLE   = 2'd0,
        DEB_CHK_HI = 2'd1,
        DEB_HELD   = 2'd2,
        DEB_CHK_LO = 2'd3
    } deb_state_t;

    function automatic logic [N-1:0] period_of(input logic [1:0] m);
        case (m)
            2'd0:    period_of = DIV0_C;
            2'd1:    period_of = DIV1_C;
            2'd2:    period_of = DIV2_C;
            2'd3:    period_of = DIV3_C;
            default: period_of = DIV0_C;
        endcase
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    deb_state_t       deb_state_r;
    deb_state_t       deb_state_nxt_s;
    logic [DW-1:0]    deb_cnt_r;
    logic [DW-1:0]    deb_cnt_nxt_s;
    logic             press_s;

    logic [N-1:0]     cnt_r;
    logic [N-1:0]     cnt_step_s;
    logic [N-1:0]     div_s;
    logic [N-1:0]     last_s;
    logic [N-1:0]     half_s;
    logic             wrap_s;
    logic             boundary_s;
    logic             apply_s;

    logic [1:0]       pend_mode_r;
    logic [1:0]       base_s;
    logic             req_s;
    logic [1:0]       req_mode_s;

    // Two-flop synchroniser for the asynchronous pushbutton.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_next;
            sync2_r <= sync1_r;
        end
    end

    // Debouncer state and stable-level counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_state_r <= DEB_IDLE;
            deb_cnt_r   <= '0;
        end else begin
            deb_state_r <= deb_state_nxt_s;
            deb_cnt_r   <= deb_cnt_nxt_s;
        end
    end

    // Debouncer next state; the press pulse fires once when a high level has been stable long enough.
    always_comb begin
        deb_state_nxt_s = deb_state_r;
        deb_cnt_nxt_s   = deb_cnt_r;
        press_s         = 1'b0;
        case (deb_state_r)
            DEB_IDLE: begin
                if (sync2_r) begin
                    deb_state_nxt_s = DEB_CHK_HI;
                    deb_cnt_nxt_s   = '0;
                end else begin
                    deb_state_nxt_s = DEB_IDLE;
                end
            end
            DEB_CHK_HI: begin
                if (!sync2_r) begin
                    deb_state_nxt_s = DEB_IDLE;
                end else if (deb_cnt_r >= DEB_LAST) begin
                    deb_state_nxt_s = DEB_HELD;
                    press_s         = 1'b1;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DW'(1);
                end
            end
            DEB_HELD: begin
                if (!sync2_r) begin
                    deb_state_nxt_s = DEB_CHK_LO;
                    deb_cnt_nxt_s   = '0;
                end else begin
                    deb_state_nxt_s = DEB_HELD;
                end
            end
            DEB_CHK_LO: begin
                if (sync2_r) begin
                    deb_state_nxt_s = DEB_HELD;
                end else if (deb_cnt_r >= DEB_LAST) begin
                    deb_state_nxt_s = DEB_IDLE;
                end else begin
                    deb_cnt_nxt_s = deb_cnt_r + DW'(1);
                end
            end
            default: begin
                deb_state_nxt_s = DEB_IDLE;
                deb_cnt_nxt_s   = '0;
            end
        endcase
    end

    // Period decode, wrap detection and boundary/apply qualification.
    always_comb begin
        div_s  = period_of(mode);
        last_s = div_s - N'(1);
        half_s = div_s >> 1;
        wrap_s = (cnt_r >= last_s);
        if (wrap_s) begin
            cnt_step_s = '0;
        end else begin
            cnt_step_s = cnt_r + N'(1);
        end
        boundary_s = run & wrap_s;
        apply_s    = pending & (boundary_s | ~run);
    end

    // Request arbitration; presses build on the waiting mode so repeated presses accumulate.
    always_comb begin
        if (pending) begin
            base_s = pend_mode_r;
        end else begin
            base_s = mode;
        end
        if (mode_load) begin
            req_s      = 1'b1;
            req_mode_s = mode_in;
        end else if (press_s) begin
            req_s      = 1'b1;
            req_mode_s = base_s + 2'd1;
        end else begin
            req_s      = 1'b0;
            req_mode_s = base_s;
        end
    end

    // Pending request register; a request in the apply cycle survives for the next boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending     <= 1'b0;
            pend_mode_r <= 2'd0;
        end else if (req_s) begin
            pending     <= 1'b1;
            pend_mode_r <= req_mode_s;
        end else if (apply_s) begin
            pending <= 1'b0;
        end
    end

    // Period counter with registered square wave and tick; mode switches restart the period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode  <= 2'd0;
            cnt_r <= '0;
            q     <= 1'b0;
            tick  <= 1'b0;
        end else if (apply_s) begin
            mode  <= pend_mode_r;
            cnt_r <= '0;
            q     <= 1'b0;
            tick  <= boundary_s;
        end else if (run) begin
            cnt_r <= cnt_step_s;
            q     <= (cnt_step_s >= half_s);
            tick  <= wrap_s;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule
